bcd_display_converter: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the per-digit seven-segment decoders.
- Takes an ALU result word and produces DIGITS packed 4-bit BCD nibbles, one per display decoder, plus leading-zero blank and overflow/sign flags for the display layer.

---
 rtl/bcd_display_converter.sv | 135 +++++++++++++
 tb/tb_bcd_display_converter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment decoders, one bit per clock.
// Optional macro BCD_SIGNED_INPUT_EN: value is two's complement, magnitude is converted and sign reported.
module bcd_display_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    value,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] digits,
   output logic [DIGITS-1:0]   blank,
   output logic                overflow,
   output logic                negative
);

   localparam int CntW = $clog2(WIDTH + 1);
   localparam logic [DIGITS-1:0] BlankReset = ~DIGITS'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

   state_e              state_q;
   logic [WIDTH-1:0]    bin_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [4*DIGITS-1:0] bcdAdj;
   logic [4*DIGITS-1:0] bcd_d;
   logic [CntW-1:0]     cnt_q;
   logic                ovfSticky_q;
   logic                busy_q;
   logic                done_q;
   logic [4*DIGITS-1:0] digits_q;
   logic [DIGITS-1:0]   blank_q;
   logic [DIGITS-1:0]   blankCalc;
   logic                allZero;
   logic                overflow_q;
   logic [WIDTH-1:0]    capMag;

`ifdef BCD_SIGNED_INPUT_EN
   logic signCap_q;
   logic negative_q;
   // Plain negation also covers the most negative value: its WIDTH-bit pattern is already the magnitude.
   assign capMag   = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
   assign negative = negative_q;
`else
   assign capMag   = value;
   assign negative = 1'b0;
`endif

   always_comb begin
      bcdAdj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // The top adjusted nibble's MSB is the decimal carry that falls off the display.
   assign bcd_d = {bcdAdj[4*DIGITS-2:0], bin_q[WIDTH-1]};

   always_comb begin
      blankCalc = '0;
      allZero   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         allZero      = allZero & (bcd_q[4*i +: 4] == 4'd0);
         blankCalc[i] = allZero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         ovfSticky_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         digits_q    <= '0;
         blank_q     <= BlankReset;
         overflow_q  <= 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
         signCap_q   <= 1'b0;
         negative_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  bin_q       <= capMag;
                  bcd_q       <= '0;
                  ovfSticky_q <= 1'b0;
                  cnt_q       <= CntW'(WIDTH);
                  busy_q      <= 1'b1;
                  state_q     <= SHIFT;
`ifdef BCD_SIGNED_INPUT_EN
                  signCap_q   <= value[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               bin_q       <= {bin_q[WIDTH-2:0], 1'b0};
               bcd_q       <= bcd_d;
               ovfSticky_q <= ovfSticky_q | bcdAdj[4*DIGITS-1];
               cnt_q       <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               digits_q   <= bcd_q;
               blank_q    <= blankCalc;
               overflow_q <= ovfSticky_q;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
`ifdef BCD_SIGNED_INPUT_EN
               negative_q <= signCap_q;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign digits   = digits_q;
   assign blank    = blank_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_display_converter.sv
// Bench for bcd_display_converter: a decimal-arithmetic model checked every cycle plus literal vectors.
// Runs two instances (6 and 4 digits) from the same stimulus; honours BCD_SIGNED_INPUT_EN.
module tb_bcd_display_converter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] value;
   logic        busy6, done6, ovf6, neg6;
   logic [23:0] digits6;
   logic [5:0]  blank6;
   logic        busy4, done4, ovf4, neg4;
   logic [15:0] digits4;
   logic [3:0]  blank4;

   int vectors = 0;
   int miscompares = 0;

   bcd_display_converter #(.WIDTH(16), .DIGITS(6)) dut (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy6), .done(done6), .digits(digits6), .blank(blank6),
      .overflow(ovf6), .negative(neg6)
   );

   bcd_display_converter #(.WIDTH(16), .DIGITS(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy4), .done(done4), .digits(digits4), .blank(blank4),
      .overflow(ovf4), .negative(neg4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected display contents of a magnitude on an nd-digit display, by decimal arithmetic.
   function automatic void calcExp(input longint mag, input int nd,
                                   output logic [31:0] dig, output logic [31:0] blk,
                                   output logic ovf);
      longint lim = 1;
      longint m;
      longint p = 1;
      dig = '0;
      blk = '0;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      ovf = (mag >= lim);
      m = mag % lim;
      for (int i = 0; i < nd; i++) begin
         dig[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      for (int i = 1; i < nd; i++) begin
         p = p * 10;
         blk[i] = ((mag % lim) < p);
      end
   endfunction

   // Transaction-level model: a conversion started on an idle edge completes WIDTH+1 edges later.
   int          mPhase = 0;
   longint      mMag = 0;
   logic        mNegCap = 1'b0;
   logic        expBusy = 1'b0, expDone = 1'b0, expNeg = 1'b0;
   logic [31:0] expDig6 = '0, expBlk6 = '0, expDig4 = '0, expBlk4 = '0;
   logic        expOvf6 = 1'b0, expOvf4 = 1'b0;
   logic        checkEn = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         checkEn = 1'b1;
         mPhase  = 0;
         expBusy = 1'b0;
         expDone = 1'b0;
         expNeg  = 1'b0;
         expDig6 = '0;
         expBlk6 = 32'b111110;
         expOvf6 = 1'b0;
         expDig4 = '0;
         expBlk4 = 32'b1110;
         expOvf4 = 1'b0;
      end else begin
         expDone = 1'b0;
         if (mPhase == 0) begin
            if (start) begin
`ifdef BCD_SIGNED_INPUT_EN
               mNegCap = value[15];
               mMag    = value[15] ? (65536 - longint'(value)) : longint'(value);
`else
               mNegCap = 1'b0;
               mMag    = longint'(value);
`endif
               mPhase  = 17;
               expBusy = 1'b1;
            end
         end else begin
            mPhase = mPhase - 1;
            if (mPhase == 0) begin
               expDone = 1'b1;
               expBusy = 1'b0;
               expNeg  = mNegCap;
               calcExp(mMag, 6, expDig6, expBlk6, expOvf6);
               calcExp(mMag, 4, expDig4, expBlk4, expOvf4);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy6", 32'(busy6), 32'(expBusy));
         checkOutput("done6", 32'(done6), 32'(expDone));
         checkOutput("digits6", 32'(digits6), expDig6);
         checkOutput("blank6", 32'(blank6), expBlk6);
         checkOutput("overflow6", 32'(ovf6), 32'(expOvf6));
         checkOutput("negative6", 32'(neg6), 32'(expNeg));
         checkOutput("busy4", 32'(busy4), 32'(expBusy));
         checkOutput("done4", 32'(done4), 32'(expDone));
         checkOutput("digits4", 32'(digits4), expDig4);
         checkOutput("blank4", 32'(blank4), expBlk4);
         checkOutput("overflow4", 32'(ovf4), 32'(expOvf4));
      end
   end

   // Start one conversion from idle and return the number of edges from the accepting edge to done.
   task automatic applyStimulus(input logic [15:0] v, output int lat);
      start = 1'b1;
      value = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      value = 16'($urandom);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done6) begin
            lat = n;
            break;
         end
      end
   endtask

   int lat;
   int doneCount;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      value = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rstBusy", 32'(busy6), 32'd0);
      checkOutput("rstDone", 32'(done6), 32'd0);
      checkOutput("rstDigits", 32'(digits6), 32'h0);
      checkOutput("rstBlank", 32'(blank6), 32'b111110);
      checkOutput("rstOverflow", 32'(ovf6), 32'd0);

      applyStimulus(16'd12345, lat);
      checkOutput("latency12345", 32'(lat), 32'd17);
      checkOutput("dig12345", 32'(digits6), 32'h012345);
      checkOutput("blank12345", 32'(blank6), 32'b100000);
      checkOutput("ovf12345", 32'(ovf6), 32'd0);
      checkOutput("dig4_12345", 32'(digits4), 32'h2345);
      checkOutput("ovf4_12345", 32'(ovf4), 32'd1);

      applyStimulus(16'hFFFF, lat);
      checkOutput("latencyFFFF", 32'(lat), 32'd17);
`ifdef BCD_SIGNED_INPUT_EN
      checkOutput("digFFFFs", 32'(digits6), 32'h000001);
      checkOutput("negFFFFs", 32'(neg6), 32'd1);
      checkOutput("blankFFFFs", 32'(blank6), 32'b111110);
      applyStimulus(16'h8000, lat);
      checkOutput("dig8000s", 32'(digits6), 32'h032768);
      checkOutput("neg8000s", 32'(neg6), 32'd1);
`else
      checkOutput("digFFFF", 32'(digits6), 32'h065535);
      checkOutput("blankFFFF", 32'(blank6), 32'b100000);
`endif

      applyStimulus(16'd0, lat);
      checkOutput("dig0", 32'(digits6), 32'h0);
      checkOutput("blank0", 32'(blank6), 32'b111110);

      applyStimulus(16'd9999, lat);
      checkOutput("dig4_9999", 32'(digits4), 32'h9999);
      checkOutput("ovf4_9999", 32'(ovf4), 32'd0);

      // start held high with value changing every cycle: accepts every 18 edges.
      doneCount = 0;
      start = 1'b1;
      for (int n = 0; n < 60; n++) begin
         value = 16'($urandom);
         @(posedge clk);
         #1;
         if (done6) doneCount++;
      end
      start = 1'b0;
      checkOutput("heldDones", 32'(doneCount), 32'd3);
      for (int n = 0; n < 40 && busy6; n++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("heldDrain", 32'(busy6), 32'd0);

      // Reset after eight shifts: abort with no done pulse.
      start = 1'b1;
      value = 16'd4321;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      doneCount = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk);
         #1;
         if (done6) doneCount++;
      end
      checkOutput("abortDones", 32'(doneCount), 32'd0);
      checkOutput("abortBusy", 32'(busy6), 32'd0);
      checkOutput("abortDigits", 32'(digits6), 32'h0);
      checkOutput("abortBlank", 32'(blank6), 32'b111110);
      checkOutput("abortOverflow", 32'(ovf6), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
